// File: rtl/slifo_arb_pkg.sv
// Shared types and constants for the LIFO requester arbiter.
package slifo_arb_pkg;

  // Controller modes: normal arbitration, or draining the LIFO.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Meaning of a requester's op bit.
  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  // Width of the requester id carried down the read pipeline.
  // Sized generously so the struct does not depend on NUM_REQ.
  localparam int PIPE_ID_W = 8;

  // One slot of the read-return pipeline.
  //   valid : a lifo_rd was issued in the cycle this slot was loaded
  //   flush : the read belonged to a flush and must not produce rvalid
  //   id    : requester that owns the returning data
  typedef struct packed {
    logic                 valid;
    logic                 flush;
    logic [PIPE_ID_W-1:0] id;
  } pipe_entry_t;

  // Build a pipeline slot from its fields.
  function automatic pipe_entry_t make_entry(input logic                 valid,
                                             input logic                 flush,
                                             input logic [PIPE_ID_W-1:0] id);
    pipe_entry_t e;
    e.valid = valid;
    e.flush = flush;
    e.id    = id;
    return e;
  endfunction

endpackage

// File: rtl/slifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester at or
// after ptr wins. The eligible vector is doubled so the wrap-around
// search is a plain linear scan starting at ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int SW = $clog2(2 * NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] hit;
  logic [SW-1:0]        pos;
  logic                 found;

  // Scan NUM_REQ positions from ptr in the doubled vector, then fold the
  // single hit back onto the original requester index.
  always_comb begin
    dbl   = {eligible, eligible};
    hit   = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = SW'(ptr) + SW'(k);
      if (!found && dbl[pos]) begin
        hit[pos] = 1'b1;
        found    = 1'b1;
      end
    end
    gnt = hit[NUM_REQ-1:0] | hit[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/slifo_arbiter.sv
// Shares one synchronous LIFO between NUM_REQ requesters. One operation
// per cycle is granted round-robin; an internal occupancy count keeps the
// LIFO from over- or underflowing; pop data is routed back to its owner
// RD_LATENCY cycles after the grant; flush_req drains the LIFO.
//
// Handshake: req[i] is a level held until gnt[i]. gnt[i] is a one-cycle
// pulse, combinational in the cycle the operation is issued to the LIFO;
// the operation takes effect at the closing clock edge, after which the
// requester drops or changes req[i]. rvalid[i] is a one-cycle pulse with
// rdata valid in the same cycle; there is no backpressure on returns.
module slifo_arbiter
  import slifo_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int POINTER_WIDTH = 3,
  parameter int RD_LATENCY    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          flush_req,
  output logic                          flush_busy,
  output logic [POINTER_WIDTH:0]        level,
  output logic                          lifo_wr,
  output logic                          lifo_rd,
  output logic [DATA_WIDTH-1:0]         lifo_din,
  input  logic [DATA_WIDTH-1:0]         lifo_dout,
  output state_t                        dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [POINTER_WIDTH:0] LEVEL_FULL = (POINTER_WIDTH + 1)'(DEPTH);

  state_t                  state_q;
  logic [POINTER_WIDTH:0]  level_q;
  logic [IDX_W-1:0]        ptr_q;
  pipe_entry_t             pipe_q [RD_LATENCY];
  pipe_entry_t             new_entry;
  pipe_entry_t             tail;

  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]        win_idx;
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic                    grant_any;
  logic                    grant_push;
  logic                    grant_pop;
  logic                    flush_rd;
  logic                    user_pop_pending;

  // Split the flat push-data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata_arr[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A request is eligible only in RUN and only if the LIFO can honour it;
  // ineligible requesters drop out of the search instead of blocking it.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == ST_RUN && req[i]) begin
        if (op[i] == OP_PUSH) elig[i] = (level_q < LEVEL_FULL);
        else                  elig[i] = (level_q != '0);
      end
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible (elig),
    .ptr      (ptr_q),
    .gnt      (arb_gnt)
  );

  // Encode the one-hot winner into an index.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_idx = IDX_W'(i);
    end
  end

  // Decode the winning operation into LIFO strobes. Grants are held off
  // while rst is high so no strobe leaks out during an async reset.
  always_comb begin
    grant_any  = !rst && (arb_gnt != '0);
    grant_push = grant_any && (op[win_idx] == OP_PUSH);
    grant_pop  = grant_any && (op[win_idx] == OP_POP);
    flush_rd   = (state_q == ST_FLUSH) && (level_q != '0);
    gnt        = grant_any ? arb_gnt : '0;
    lifo_wr    = grant_push;
    lifo_rd    = grant_pop || flush_rd;
    lifo_din   = grant_push ? wdata_arr[win_idx] : '0;
  end

  // Slot describing this cycle's read, entering the return pipeline.
  always_comb begin
    new_entry = make_entry(lifo_rd, flush_rd,
                           grant_pop ? PIPE_ID_W'(win_idx) : '0);
  end

  // A non-flush pop still in flight keeps FLUSH from exiting, so its data
  // is delivered before requesters can touch the LIFO again.
  always_comb begin
    user_pop_pending = 1'b0;
    for (int s = 0; s < RD_LATENCY; s++) begin
      if (pipe_q[s].valid && !pipe_q[s].flush) user_pop_pending = 1'b1;
    end
  end

  // Return path: the oldest slot pairs with lifo_dout this cycle.
  always_comb begin
    tail   = pipe_q[RD_LATENCY-1];
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid[i] = tail.valid && !tail.flush && (tail.id == PIPE_ID_W'(i));
    end
    rdata = (rvalid != '0) ? lifo_dout : '0;
  end

  // Mode FSM: RUN arbitrates; FLUSH drains until empty and no owned pop
  // is in flight. flush_busy is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      flush_busy <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush_req) begin
            state_q    <= ST_FLUSH;
            flush_busy <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (level_q == '0 && !user_pop_pending) begin
            state_q    <= ST_RUN;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy tracks every strobe sent to the LIFO; wr and rd never
  // coincide, so only one direction applies per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else if (lifo_wr) begin
      level_q <= level_q + 1'b1;
    end else if (lifo_rd) begin
      level_q <= level_q - 1'b1;
    end
  end

  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_any) begin
      ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Read-return shift pipeline, RD_LATENCY slots deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= new_entry;
      for (int s = 1; s < RD_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign level     = level_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_slifo_arbiter.sv
// Bench for slifo_arbiter: a small LIFO device model answers the DUT's
// strobes, and a queue-based reference predicts grants, strobes, level,
// flush_busy and returned data every cycle.
module tb_slifo_arbiter;
  import slifo_arb_pkg::*;

  localparam int NR     = 4;
  localparam int DW     = 8;
  localparam int DEP    = 8;
  localparam int PW     = 3;
  localparam int RD_LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req, op;
  logic [NR*DW-1:0] wdata;
  logic             flush_req;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic             flush_busy;
  logic [PW:0]      level;
  logic             lifo_wr, lifo_rd;
  logic [DW-1:0]    lifo_din, lifo_dout;
  state_t           dbg_state;

  slifo_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEP), .POINTER_WIDTH(PW), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .flush_req(flush_req), .flush_busy(flush_busy), .level(level),
    .lifo_wr(lifo_wr), .lifo_rd(lifo_rd), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .dbg_state(dbg_state)
  );

  // ---------------- LIFO device model ----------------
  logic [DW-1:0] mem [DEP];
  int            sp;
  logic [DW-1:0] rd_chain [RD_LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
      for (int s = 0; s < RD_LAT; s++) rd_chain[s] <= '0;
    end else begin
      if (lifo_rd && sp > 0) begin
        rd_chain[0] <= mem[sp-1];
        sp <= sp - 1;
      end
      if (lifo_wr && sp < DEP) begin
        mem[sp] <= lifo_din;
        sp <= sp + 1;
      end
      for (int s = 1; s < RD_LAT; s++) rd_chain[s] <= rd_chain[s-1];
    end
  end
  assign lifo_dout = rd_chain[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] exp_q[$];   // stack contents, top = last element
  ret_t          m_ret[$];   // pops owed to requesters
  int            m_rr;
  bit            m_flush;
  int            cyc;
  logic [NR-1:0] last_gnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ret.delete();
    m_rr     = 0;
    m_flush  = 0;
    last_gnt = '0;
  endtask

  // All outputs must be zero while rst is asserted.
  task automatic chk_zero();
    chk("rst_gnt",    gnt,        0);
    chk("rst_rvalid", rvalid,     0);
    chk("rst_wr",     lifo_wr,    0);
    chk("rst_rd",     lifo_rd,    0);
    chk("rst_busy",   flush_busy, 0);
    chk("rst_level",  level,      0);
    chk("rst_din",    lifo_din,   0);
    chk("rst_rdata",  rdata,      0);
    chk("rst_state",  dbg_state,  ST_RUN);
  endtask

  // Async reset pulse landing mid-cycle.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    chk_zero();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: predict, compare, advance the model across the edge.
  task automatic step();
    logic [NR-1:0] e_gnt, e_rvalid;
    logic          e_wr, e_rd;
    logic [DW-1:0] e_din, e_rdata, d;
    int            win, lvl;
    bit            pend;
    #1;
    lvl = exp_q.size();
    e_gnt = '0; e_rvalid = '0; e_wr = 0; e_rd = 0; e_din = '0; e_rdata = '0;
    win = -1; pend = 0;
    foreach (m_ret[j]) begin
      if (m_ret[j].due == cyc) begin
        e_rvalid[m_ret[j].id] = 1'b1;
        e_rdata = m_ret[j].data;
      end
      if (m_ret[j].due >= cyc) pend = 1;
    end
    if (!m_flush) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (win < 0 && req[i] && (op[i] ? (lvl < DEP) : (lvl > 0))) win = i;
      end
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        if (op[win]) begin
          e_wr  = 1;
          e_din = wdata[win*DW +: DW];
        end else begin
          e_rd = 1;
        end
      end
    end else begin
      e_rd = (lvl > 0);
    end

    chk("gnt",        gnt,        e_gnt);
    chk("lifo_wr",    lifo_wr,    e_wr);
    chk("lifo_rd",    lifo_rd,    e_rd);
    chk("level",      level,      lvl);
    chk("flush_busy", flush_busy, m_flush);
    chk("rvalid",     rvalid,     e_rvalid);
    if (e_wr)          chk("lifo_din", lifo_din, e_din);
    if (e_rvalid != 0) chk("rdata",    rdata,    e_rdata);

    if (e_wr) exp_q.push_back(e_din);
    if (e_rd) begin
      d = exp_q.pop_back();
      if (!m_flush) m_ret.push_back('{due: cyc + RD_LAT, id: win, data: d});
    end
    if (win >= 0) m_rr = (win + 1) % NR;
    for (int j = m_ret.size() - 1; j >= 0; j--) begin
      if (m_ret[j].due == cyc) m_ret.delete(j);
    end
    if (!m_flush) begin
      if (flush_req) m_flush = 1;
    end else if (lvl == 0 && !pend) begin
      m_flush = 0;
    end
    last_gnt = e_gnt;
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; req = '0; op = '0; wdata = '0; flush_req = 1'b0;
    cyc = 0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_zero();
    @(negedge clk);
    rst = 1'b0;

    // Round trip: push 0x11, 0x22, pop twice.
    req = 4'b0001; op = 4'b0001; wdata[7:0] = 8'h11;
    step(); chk("rt_level_a", level, 1);
    wdata[7:0] = 8'h22;
    step(); chk("rt_level_b", level, 2);
    op[0] = 1'b0;
    step(); chk("rt_level_c", level, 1);
    chk("rt_rvalid_a", rvalid, 4'b0001); chk("rt_rdata_a", rdata, 8'h22);
    step(); chk("rt_level_d", level, 0);
    chk("rt_rvalid_b", rvalid, 4'b0001); chk("rt_rdata_b", rdata, 8'h11);
    req = '0;
    step();

    // Round robin: everyone pushes until full.
    do_reset();
    req = 4'b1111; op = 4'b1111;
    for (int n = 0; n < 10; n++) begin
      wdata = $urandom;
      step();
    end
    chk("rr_full", level, DEP);
    chk("rr_stall_gnt", gnt, 0);

    // Mixed eligibility at full: the pop wins, then the push.
    req = 4'b0110; op = 4'b0010; wdata[15:8] = 8'hC3;
    step(); chk("mix_level_a", level, 7);
    req = 4'b0010;
    step(); chk("mix_level_b", level, 8);

    // Pop down to 5, then flush while requests are pending.
    req = 4'b0001; op = 4'b0000;
    repeat (3) step();
    chk("fl_level_start", level, 5);
    req = '0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("fl_busy", flush_busy, 1);
    req = 4'b1111; op = 4'b1111;
    repeat (6) step();
    req = '0;
    chk("fl_level_end", level, 0);
    chk("fl_state_end", dbg_state, ST_RUN);
    step();

    // Empty guard: a held pop stalls until a push lands.
    req = 4'b1000; op = 4'b0000;
    repeat (5) step();
    req[0] = 1'b1; op[0] = 1'b1; wdata[7:0] = 8'h5A;
    step();
    req[0] = 1'b0;
    step();
    req = '0;
    chk("eg_rvalid", rvalid, 4'b1000);
    chk("eg_rdata",  rdata,  8'h5A);
    step();

    // Reset in the middle of a flush.
    req = 4'b0001; op = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      wdata[7:0] = 8'($urandom);
      step();
    end
    req = '0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    req = 4'b1111; op = 4'b1111;
    do_reset();
    req = '0;
    repeat (4) step();

    // Random traffic with held requests and occasional flushes.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] || last_gnt[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          op[i]  = 1'($urandom_range(0, 1));
          wdata[i*DW +: DW] = 8'($urandom);
        end
      end
      flush_req = ($urandom_range(0, 40) == 0);
      if (n == 250) do_reset();
      step();
    end
    flush_req = 1'b0; req = '0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
